// File: rtl/cp0_pkg.sv
// Purpose: shared constants for the CP0 block (register numbers, field positions, codes).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR field positions
  localparam int SR_IM_HI = 15;
  localparam int SR_IM_LO = 10;
  localparam int SR_EXL   = 1;
  localparam int SR_IE    = 0;

  // Cause field positions
  localparam int CAUSE_BD    = 31;
  localparam int CAUSE_IP_HI = 15;
  localparam int CAUSE_IP_LO = 10;
  localparam int CAUSE_EC_HI = 6;
  localparam int CAUSE_EC_LO = 2;

  // Constants
  localparam logic [31:0] PRID_VAL   = 32'h18231051;
  localparam logic [31:0] EXC_VECTOR = 32'h00004180;

  // Exception codes
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Reset values of the SR fields
  localparam logic [5:0] SR_IM_RST  = 6'h3F;
  localparam logic       SR_EXL_RST = 1'b0;
  localparam logic       SR_IE_RST  = 1'b1;

endpackage

// File: rtl/cp0_irq_arb.sv
// Purpose: decides whether to take an interrupt/exception and which ExcCode to record.
// Latency: purely combinational, zero cycles.
// Backpressure: none; exceptions are masked while EXL is set.
module cp0_irq_arb
  import cp0_pkg::*;
(
  input  logic [5:0] hw_int,
  input  logic [5:0] sr_im,
  input  logic       sr_exl,
  input  logic       sr_ie,
  input  logic       exc,
  input  logic [4:0] exc_code,
  output logic       int_pend,
  output logic       exc_pend,
  output logic       int_req,
  output logic [4:0] next_exc_code
);

  // An interrupt beats a simultaneous synchronous exception and records code 0.
  always_comb begin
    int_pend      = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
    exc_pend      = exc & ~sr_exl;
    int_req       = int_pend | exc_pend;
    next_exc_code = int_pend ? EXC_INT : exc_code;
  end

endmodule

// File: rtl/cp0_unit.sv
// Purpose: MIPS-style CP0 holding SR, Cause, EPC and PRId; raises the flush/vector request.
// Latency: oIntReq and oRData are combinational; register updates land one edge later.
// Backpressure: none; exceptions arriving while EXL=1 are dropped.
module cp0_unit
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iPC,
  input  logic        iEXC,
  input  logic [4:0]  iExcCode,
  input  logic        iisBJ,
  input  logic [5:0]  iHWInt,
  input  logic        iWE,
  input  logic [4:0]  iAddr,
  input  logic [31:0] iWData,
  input  logic        iERET,
  output logic [31:0] oRData,
  output logic        oIntReq,
  output logic [31:0] oEPC
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_pend;
  logic        exc_pend;
  logic        int_req;
  logic [4:0]  next_exc_code;

  logic [31:0] sr_val;
  logic [31:0] cause_val;

  cp0_irq_arb u_arb (
    .hw_int        (iHWInt),
    .sr_im         (im_q),
    .sr_exl        (exl_q),
    .sr_ie         (ie_q),
    .exc           (iEXC),
    .exc_code      (iExcCode),
    .int_pend      (int_pend),
    .exc_pend      (exc_pend),
    .int_req       (int_req),
    .next_exc_code (next_exc_code)
  );

  // Next-state: taking an exception wins over mtc0/eret; eret's EXL clear wins over mtc0.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = iHWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (int_req) begin
      exl_d      = 1'b1;
      exc_code_d = next_exc_code;
      bd_d       = iisBJ;
      epc_d      = iisBJ ? (iPC - 32'd4) : iPC;
    end else begin
      if (iWE) begin
        if (iAddr == REG_SR) begin
          im_d  = iWData[SR_IM_HI:SR_IM_LO];
          exl_d = iWData[SR_EXL];
          ie_d  = iWData[SR_IE];
        end else if (iAddr == REG_EPC) begin
          epc_d = {iWData[31:2], 2'b00};
        end
      end
      if (iERET) begin
        exl_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset that overrides every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= SR_IM_RST;
      exl_q      <= SR_EXL_RST;
      ie_q       <= SR_IE_RST;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= EXC_INT;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // Register images with unimplemented bits forced to zero, and the mfc0 read mux.
  always_comb begin
    sr_val = 32'd0;
    sr_val[SR_IM_HI:SR_IM_LO] = im_q;
    sr_val[SR_EXL] = exl_q;
    sr_val[SR_IE]  = ie_q;
    cause_val = 32'd0;
    cause_val[CAUSE_BD] = bd_q;
    cause_val[CAUSE_IP_HI:CAUSE_IP_LO] = ip_q;
    cause_val[CAUSE_EC_HI:CAUSE_EC_LO] = exc_code_q;
    case (iAddr)
      REG_SR:    oRData = sr_val;
      REG_CAUSE: oRData = cause_val;
      REG_EPC:   oRData = epc_q;
      REG_PRID:  oRData = PRID_VAL;
      default:   oRData = 32'd0;
    endcase
  end

  assign oIntReq = int_req;
  assign oEPC    = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Purpose: directed scoreboard bench for cp0_unit; expectations queued by stimulus, checked by a monitor.
// Latency: checks sample on the falling edge within the cycle the inputs were applied.
// Backpressure: n/a.
module tb_cp0_unit;

  logic        clk;
  logic        reset;
  logic [31:0] iPC;
  logic        iEXC;
  logic [4:0]  iExcCode;
  logic        iisBJ;
  logic [5:0]  iHWInt;
  logic        iWE;
  logic [4:0]  iAddr;
  logic [31:0] iWData;
  logic        iERET;
  logic [31:0] oRData;
  logic        oIntReq;
  logic [31:0] oEPC;

  localparam int SEL_RD  = 0;
  localparam int SEL_INT = 1;
  localparam int SEL_EPC = 2;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  cp0_unit dut (
    .clk      (clk),
    .reset    (reset),
    .iPC      (iPC),
    .iEXC     (iEXC),
    .iExcCode (iExcCode),
    .iisBJ    (iisBJ),
    .iHWInt   (iHWInt),
    .iWE      (iWE),
    .iAddr    (iAddr),
    .iWData   (iWData),
    .iERET    (iERET),
    .oRData   (oRData),
    .oIntReq  (oIntReq),
    .oEPC     (oEPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  // Monitor: drain every queued expectation against the outputs on the falling edge.
  initial begin
    chk_t c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        c = sb.pop_front();
        case (c.sel)
          SEL_RD:  act = oRData;
          SEL_INT: act = {31'd0, oIntReq};
          default: act = oEPC;
        endcase
        n_cmp++;
        if (act !== c.exp) begin
          n_bad++;
          $display("FAIL %s: actual=%08h required=%08h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset    = 1'b0;
    iPC      = 32'd0;
    iEXC     = 1'b0;
    iExcCode = 5'd0;
    iisBJ    = 1'b0;
    iHWInt   = 6'd0;
    iWE      = 1'b0;
    iAddr    = 5'd0;
    iWData   = 32'd0;
    iERET    = 1'b0;
  endtask

  task automatic chk(input string name, input int sel, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bj);
    iEXC = 1'b1; iExcCode = code; iPC = pc; iisBJ = bj;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    iWE = 1'b1; iAddr = addr; iWData = data;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(); idle(); reset = 1'b1;
    tick(); idle(); reset = 1'b1;

    // Reset values and read mux
    tick(); idle(); iAddr = 5'd12;
    chk("por_sr", SEL_RD, 32'h0000FC01); chk("por_int", SEL_INT, 32'd0); chk("por_epc", SEL_EPC, 32'd0);
    tick(); idle(); iAddr = 5'd13; chk("por_cause", SEL_RD, 32'd0);
    tick(); idle(); iAddr = 5'd15; chk("prid", SEL_RD, 32'h18231051);
    tick(); idle(); iAddr = 5'd7;  chk("unimpl_rd", SEL_RD, 32'd0);
    tick(); idle(); iAddr = 5'd14; chk("por_epc_rd", SEL_RD, 32'd0);

    // Overflow exception, not in a delay slot
    tick(); idle(); exc(5'd12, 32'h3010, 1'b0);
    chk("ov_int", SEL_INT, 32'd1); chk("ov_epc_nobypass", SEL_EPC, 32'd0);
    tick(); idle(); iAddr = 5'd13; exc(5'd10, 32'h7777, 1'b0);
    chk("ov_cause", SEL_RD, 32'h00000030); chk("ov_epc", SEL_EPC, 32'h3010); chk("exl_mask_int", SEL_INT, 32'd0);
    tick(); idle(); iAddr = 5'd12; chk("ov_sr", SEL_RD, 32'h0000FC03);
    tick(); idle(); iAddr = 5'd13; iExcCode = 5'd5;
    chk("masked_cause", SEL_RD, 32'h00000030); chk("masked_epc", SEL_EPC, 32'h3010);
    tick(); idle(); iAddr = 5'd12; iERET = 1'b1;
    chk("eret_int", SEL_INT, 32'd0); chk("eret_sr_pre", SEL_RD, 32'h0000FC03);
    tick(); idle(); iAddr = 5'd12; chk("eret_sr", SEL_RD, 32'h0000FC01);

    // AdEL in a delay slot
    tick(); idle(); exc(5'd4, 32'h3024, 1'b1); chk("adel_int", SEL_INT, 32'd1);
    tick(); idle(); iAddr = 5'd13; iERET = 1'b1;
    chk("adel_cause", SEL_RD, 32'h80000010); chk("adel_epc", SEL_EPC, 32'h3020);

    // Interrupt coincident with RI: interrupt wins
    tick(); idle(); iHWInt = 6'b000100; exc(5'd10, 32'h4000, 1'b0); iAddr = 5'd12;
    chk("irq_sr_pre", SEL_RD, 32'h0000FC01); chk("irq_int", SEL_INT, 32'd1);
    tick(); idle(); iHWInt = 6'b000100; iAddr = 5'd13;
    chk("irq_cause", SEL_RD, 32'h00001000); chk("irq_epc", SEL_EPC, 32'h4000); chk("irq_exl_mask", SEL_INT, 32'd0);
    // eret together with an SR write carrying EXL=1: EXL clear wins
    tick(); idle(); iHWInt = 6'b000100; iERET = 1'b1; mtc0(5'd12, 32'h00000002);
    chk("eret_we_int", SEL_INT, 32'd0);
    tick(); idle(); iHWInt = 6'b000100; iAddr = 5'd12;
    chk("eret_we_sr", SEL_RD, 32'd0); chk("sr0_masks_irq", SEL_INT, 32'd0);

    // SR write masks unimplemented bits; Cause.IP follows the lines
    tick(); idle(); mtc0(5'd12, 32'hFFFFFFFE);
    tick(); idle(); iAddr = 5'd13; chk("ip_follow", SEL_RD, 32'd0);
    tick(); idle(); mtc0(5'd12, 32'h0000FC01); chk("sr_wmask", SEL_RD, 32'h0000FC02);
    tick(); idle(); iAddr = 5'd12; chk("sr_restore", SEL_RD, 32'h0000FC01);

    // mtc0 EPC alignment, no bypass; Cause and PRId read-only
    tick(); idle(); mtc0(5'd14, 32'h00003047);
    chk("epc_we_nobypass", SEL_EPC, 32'h4000);
    tick(); idle(); iAddr = 5'd14;
    chk("epc_we", SEL_EPC, 32'h3044); chk("epc_we_rd", SEL_RD, 32'h3044);
    tick(); idle(); mtc0(5'd13, 32'hFFFFFFFF);
    tick(); idle(); iAddr = 5'd13; chk("cause_ro", SEL_RD, 32'd0);
    tick(); idle(); mtc0(5'd15, 32'd0);
    tick(); idle(); iAddr = 5'd15; chk("prid_ro", SEL_RD, 32'h18231051);

    // SR write discarded when an exception is taken the same cycle
    tick(); idle(); mtc0(5'd12, 32'd0); exc(5'd5, 32'h5000, 1'b0); chk("ades_int", SEL_INT, 32'd1);
    tick(); idle(); iAddr = 5'd12; chk("we_discard_sr", SEL_RD, 32'h0000FC03);
    tick(); idle(); iAddr = 5'd13; iERET = 1'b1;
    chk("ades_cause", SEL_RD, 32'h00000014); chk("ades_epc", SEL_EPC, 32'h5000);

    // EPC wrap: iPC=0 in a delay slot
    tick(); idle(); exc(5'd10, 32'h0, 1'b1); chk("wrap_int", SEL_INT, 32'd1);
    tick(); idle(); iAddr = 5'd13; iERET = 1'b1;
    chk("wrap_cause", SEL_RD, 32'h80000028); chk("wrap_epc", SEL_EPC, 32'hFFFFFFFC);

    // Reset beats a simultaneous exception
    tick(); idle(); reset = 1'b1; exc(5'd12, 32'h6000, 1'b0);
    tick(); idle(); iAddr = 5'd14;
    chk("rst_exc_epc", SEL_EPC, 32'd0); chk("rst_exc_int", SEL_INT, 32'd0);
    tick(); idle(); iAddr = 5'd13; chk("rst_exc_cause", SEL_RD, 32'd0);
    tick(); idle(); iAddr = 5'd12; chk("rst_exc_sr", SEL_RD, 32'h0000FC01);

    // Interrupt gating by IE and IM
    tick(); idle(); mtc0(5'd12, 32'h0000FC00);
    tick(); idle(); iHWInt = 6'b000001; iAddr = 5'd12;
    chk("ie0_sr", SEL_RD, 32'h0000FC00); chk("ie0_mask", SEL_INT, 32'd0);
    tick(); idle(); mtc0(5'd12, 32'h00000401);
    tick(); idle(); iHWInt = 6'b000010; iAddr = 5'd12;
    chk("im_sr", SEL_RD, 32'h00000401); chk("im_mask", SEL_INT, 32'd0);
    tick(); idle(); iHWInt = 6'b000001; iPC = 32'h8000; iisBJ = 1'b1;
    chk("im_pass", SEL_INT, 32'd1);
    tick(); idle(); iAddr = 5'd13;
    chk("irq_bd_cause", SEL_RD, 32'h80000400); chk("irq_bd_epc", SEL_EPC, 32'h00007FFC);
    chk("irq_bd_int", SEL_INT, 32'd0);

    tick(); idle();
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: actual=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL provide the following ports, clock and reset first:
clk  in  1  clock; all state updates on rising edge
reset  in  1  reset, synchronous, active-high
iPC  in  32  M-stage PC of the instruction in flight, word-aligned
iEXC  in  1  M-stage exception flag
iExcCode  in  5  M-stage exception code: 4 AdEL, 5 AdES, 10 RI, 12 Ov
iisBJ  in  1  M-stage instruction sits in a branch/jump delay slot
iHWInt  in  6  hardware interrupt lines, level-sensitive
iWE  in  1  mtc0 write enable
iAddr  in  5  CP0 register number for mtc0/mfc0
iWData  in  32  mtc0 write data
iERET  in  1  eret in M stage
oRData  out  32  mfc0 read data
oIntReq  out  1  take exception/interrupt this cycle; pipeline flushes and fetches 0x00004180
oEPC  out  32  current EPC register, eret target

Function
REQ-002 SHALL implement SR (reg 12), Cause (13), EPC (14) and PRId (15).
REQ-003 SR fields SHALL be IM[15:10], EXL[1] and IE[0]; all other SR bits SHALL read 0.
REQ-004 Cause fields SHALL be BD[31], IP[15:10] and ExcCode[6:2]; all other Cause bits SHALL read 0.
REQ-005 PRId SHALL be the constant 32'h18231051.
REQ-006 oRData SHALL be combinational from iAddr; unimplemented register numbers SHALL read 32'h0.
REQ-007 Cause.IP SHALL be loaded from iHWInt on every clock edge, independent of all other events.
REQ-008 intpend SHALL be |(iHWInt & SR.IM) & SR.IE & ~SR.EXL, computed combinationally from the live iHWInt.
REQ-009 excpend SHALL be iEXC & ~SR.EXL.
REQ-010 oIntReq SHALL be intpend | excpend, combinational with zero latency.
REQ-011 On an edge with oIntReq=1, CP0 SHALL do all of the following:
- set SR.EXL <= 1
- Cause.ExcCode <= (intpend ? 0 : iExcCode); interrupt has priority over a simultaneous exception
- Cause.BD <= iisBJ
- EPC <= (iisBJ ? iPC-4 : iPC)
REQ-012 On an edge with iWE=1 and oIntReq=0, mtc0 SHALL update the target register:
- SR: only the IM, EXL and IE bits are written
- EPC: written as {iWData[31:2],2'b00}
- Cause and PRId are read-only; writes are ignored
REQ-013 On an edge with iERET=1 and oIntReq=0, CP0 SHALL clear SR.EXL; no other register changes.
REQ-014 Priority on any single edge SHALL be reset > oIntReq > (iWE, iERET).
- If iWE and iERET are both set, both take effect.
- In that case the EXL clear from iERET wins over any EXL value written by iWE.
REQ-015 oEPC SHALL show the EPC register contents with no write bypass; a new EPC value becomes visible one cycle after the writing edge.
REQ-016 iEXC asserted while SR.EXL=1 SHALL be ignored: no state change and oIntReq stays 0 unless intpend is set.
REQ-017 iExcCode SHALL be don't-care when iEXC=0; Cause.ExcCode then changes only through an interrupt (to 0).
REQ-018 EPC arithmetic SHALL be 32-bit modulo 2^32; iPC=0 with iisBJ=1 yields EPC=32'hFFFFFFFC.

Reset
REQ-019 On reset, the registers SHALL load:
- SR = 32'h0000FC01 (IM all ones, EXL=0, IE=1)
- Cause = 0
- EPC = 0
REQ-020 Reset SHALL override every simultaneous event; oIntReq SHALL be recomputed from the reset register values in the following cycle.
REQ-021 Reset asserted in the same cycle as an exception SHALL lose that exception; EPC SHALL stay 0.

Structure
REQ-022 A shared package cp0_pkg SHALL hold:
- register numbers 12–15
- field bit positions
- PRId value
- exception vector 32'h00004180
- ExcCode constants Int=0, AdEL=4, AdES=5, RI=10, Ov=12
REQ-023 A single combinational sub-module, cp0_irq_arb, SHALL compute intpend, excpend, oIntReq and the next ExcCode; all registers SHALL stay in cp0_unit.

Verification
REQ-024 Reset, then iAddr=12 -> oRData=32'h0000FC01; iAddr=15 -> 32'h18231051; iAddr=7 -> 0.
REQ-025 iEXC=1, iExcCode=12, iPC=32'h3010, iisBJ=0 -> oIntReq=1 in the same cycle; next cycle: Cause.ExcCode=12, BD=0, EPC=32'h3010, SR.EXL=1, and a second iEXC gives oIntReq=0.
REQ-026 iEXC=1, iExcCode=4, iisBJ=1, iPC=32'h3024 -> EPC=32'h3020, Cause=32'h80000010.
REQ-027 iHWInt=6'b000100 with iEXC=1, iExcCode=10 in the same cycle -> ExcCode=0, Cause.IP=6'b000100; after eret, an SR write of 0 masks the interrupt and oIntReq=0.
REQ-028 mtc0 EPC with 32'h00003047 -> oEPC=32'h00003044 one cycle later; mtc0 to Cause -> Cause unchanged.
REQ-029 mtc0 SR in the same cycle as iEXC with EXL=0 -> the write is discarded; only the exception updates are applied.
